dmem_arbiter: RTL and testbench

//  Shares the single data_mem port between the CPU and an auxiliary master (UART loader/debug DMA).

---
 rtl/dmem_arbiter.sv | 145 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data_mem port between the CPU and an
// auxiliary master (UART loader / debug DMA). Fixed CPU priority, with aux
// forced after STARVE_LIMIT consecutive CPU grants while aux is waiting.
// Optional build macro DMEM_ARB_PERF_EN adds saturating wait-cycle counters
// perf_cpu_wait / perf_aux_wait.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_memwrite,
    input  logic        cpu_memread,
    input  logic [3:0]  cpu_sign_mask,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        aux_req,
    input  logic        aux_we,
    input  logic [31:0] aux_addr,
    input  logic [31:0] aux_wdata,
    input  logic [3:0]  aux_sign_mask,
    output logic        aux_ack,
    output logic [31:0] aux_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_sign_mask,
    output logic        mem_memwrite,
    output logic        mem_memread,
    input  logic [31:0] mem_rdata,
    input  logic        mem_busy
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [15:0] perf_cpu_wait,
    output logic [15:0] perf_aux_wait
`endif
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CPU_ISS  = 3'd1,
        CPU_WAIT = 3'd2,
        AUX_ISS  = 3'd3,
        AUX_WAIT = 3'd4
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t      state;
    logic [3:0]  starve_cnt;
    logic [31:0] cpu_rdata_q;
    logic        cpu_req;
    logic        cpu_done;
    logic        aux_force;

    // A simultaneous read+write from the CPU is treated as a write.
    assign cpu_req   = cpu_memread | cpu_memwrite;
    assign aux_force = aux_req & (starve_cnt == STARVE_MAX);
    assign cpu_done  = (state == CPU_WAIT) & ~mem_busy;

    // Stall is combinational so clk_proc is gated in the same cycle.
    assign cpu_stall = cpu_req & ~cpu_done;
    assign cpu_rdata = (state == CPU_WAIT) ? mem_rdata : cpu_rdata_q;

    // Arbitration FSM: grant in IDLE, register the request in *_ISS, wait out mem_busy in *_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            starve_cnt    <= 4'd0;
            mem_addr      <= 32'd0;
            mem_wdata     <= 32'd0;
            mem_sign_mask <= 4'd0;
            mem_memwrite  <= 1'b0;
            mem_memread   <= 1'b0;
            aux_ack       <= 1'b0;
            aux_rdata     <= 32'd0;
            cpu_rdata_q   <= 32'd0;
        end else begin
            aux_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (aux_force || (aux_req && !cpu_req)) begin
                        state      <= AUX_ISS;
                        starve_cnt <= 4'd0;
                    end else if (cpu_req) begin
                        state <= CPU_ISS;
                        if (aux_req && (starve_cnt != STARVE_MAX))
                            starve_cnt <= starve_cnt + 4'd1;
                    end
                end
                CPU_ISS: begin
                    mem_addr      <= cpu_addr;
                    mem_wdata     <= cpu_wdata;
                    mem_sign_mask <= cpu_sign_mask;
                    mem_memwrite  <= cpu_memwrite;
                    mem_memread   <= cpu_memread & ~cpu_memwrite;
                    state         <= CPU_WAIT;
                end
                AUX_ISS: begin
                    mem_addr      <= aux_addr;
                    mem_wdata     <= aux_wdata;
                    mem_sign_mask <= aux_sign_mask;
                    mem_memwrite  <= aux_we;
                    mem_memread   <= ~aux_we;
                    state         <= AUX_WAIT;
                end
                CPU_WAIT: begin
                    // Track the live read data so cpu_rdata holds it after the access.
                    cpu_rdata_q <= mem_rdata;
                    if (!mem_busy) begin
                        state        <= IDLE;
                        mem_memwrite <= 1'b0;
                        mem_memread  <= 1'b0;
                    end
                end
                AUX_WAIT: begin
                    if (!mem_busy) begin
                        state        <= IDLE;
                        mem_memwrite <= 1'b0;
                        mem_memread  <= 1'b0;
                        aux_ack      <= 1'b1;
                        aux_rdata    <= mem_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_ARB_PERF_EN
    // Saturating counts of CPU stall cycles and aux cycles spent waiting for an ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cpu_wait <= 16'd0;
            perf_aux_wait <= 16'd0;
        end else begin
            if (cpu_stall && (perf_cpu_wait != 16'hFFFF))
                perf_cpu_wait <= perf_cpu_wait + 16'd1;
            if (aux_req && !aux_ack && (perf_aux_wait != 16'hFFFF))
                perf_aux_wait <= perf_aux_wait + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by a randomized run,
// every cycle compared against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_memwrite, cpu_memread, cpu_stall;
    logic [3:0]  cpu_sign_mask;
    logic        aux_req, aux_we, aux_ack;
    logic [31:0] aux_addr, aux_wdata, aux_rdata;
    logic [3:0]  aux_sign_mask;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_sign_mask;
    logic        mem_memwrite, mem_memread, mem_busy;

    dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_memwrite(cpu_memwrite), .cpu_memread(cpu_memread),
        .cpu_sign_mask(cpu_sign_mask), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_sign_mask(aux_sign_mask), .aux_ack(aux_ack), .aux_rdata(aux_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sign_mask(mem_sign_mask),
        .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
        .mem_rdata(mem_rdata), .mem_busy(mem_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int failed = 0;

    // Values the next step() applies at the falling edge.
    logic        nx_rst_n, nx_cpu_rd, nx_cpu_wr, nx_aux_req, nx_aux_we, nx_busy;
    logic [31:0] nx_cpu_addr, nx_cpu_wdata, nx_aux_addr, nx_aux_wdata, nx_rdata;
    logic [3:0]  nx_cpu_mask, nx_aux_mask;
    int          mode;  // 0 directed, 1 CPU repeats loads, 2 random

    // Reference model: one access slot (owner, issued flag) plus the mem_* view.
    int          m_owner;     // -1 none, 0 cpu, 1 aux
    bit          m_issued;
    logic [31:0] m_addr, m_wdata, m_aux_rdata, m_cpu_last;
    logic [3:0]  m_mask;
    logic        m_rd, m_wr, m_ack;
    int          m_starve;
    bit          m_cpu_done_prev;
    logic        e_stall;
    logic [31:0] e_rdata;

    // Observations of DUT behaviour for scenario-level checks.
    int obs_stall, obs_acks, obs_cpu_done, ack1_cpu, ack2_cpu;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_issued = 0;
        m_addr = '0; m_wdata = '0; m_mask = '0; m_rd = 0; m_wr = 0;
        m_ack = 0; m_aux_rdata = '0; m_cpu_last = '0; m_starve = 0;
        m_cpu_done_prev = 0;
    endtask

    task automatic model_comb();
        bit creq, in_cpu_wait;
        creq = cpu_memread | cpu_memwrite;
        in_cpu_wait = (m_owner == 0) && m_issued;
        e_stall = creq && !(in_cpu_wait && !mem_busy);
        e_rdata = in_cpu_wait ? mem_rdata : m_cpu_last;
    endtask

    task automatic model_seq();
        bit creq;
        if (!rst_n) begin
            model_reset();
            return;
        end
        creq = cpu_memread | cpu_memwrite;
        m_cpu_done_prev = creq && !e_stall;
        m_ack = 0;
        if (m_owner < 0) begin
            if (aux_req && (m_starve == LIMIT || !creq)) begin
                m_owner = 1; m_issued = 0; m_starve = 0;
            end else if (creq) begin
                m_owner = 0; m_issued = 0;
                if (aux_req && m_starve < LIMIT) m_starve++;
            end
        end else if (!m_issued) begin
            m_issued = 1;
            if (m_owner == 0) begin
                m_addr = cpu_addr; m_wdata = cpu_wdata; m_mask = cpu_sign_mask;
                m_wr = cpu_memwrite; m_rd = cpu_memread && !cpu_memwrite;
            end else begin
                m_addr = aux_addr; m_wdata = aux_wdata; m_mask = aux_sign_mask;
                m_wr = aux_we; m_rd = !aux_we;
            end
        end else begin
            if (m_owner == 0) m_cpu_last = mem_rdata;
            if (!mem_busy) begin
                if (m_owner == 1) begin
                    m_ack = 1; m_aux_rdata = mem_rdata;
                end
                m_owner = -1; m_rd = 0; m_wr = 0;
            end
        end
    endtask

    task automatic compare_all();
        model_comb();
        check("mem_addr", mem_addr, m_addr);
        check("mem_wdata", mem_wdata, m_wdata);
        check("mem_sign_mask", {28'd0, mem_sign_mask}, {28'd0, m_mask});
        check("mem_memread", {31'd0, mem_memread}, {31'd0, m_rd});
        check("mem_memwrite", {31'd0, mem_memwrite}, {31'd0, m_wr});
        check("cpu_stall", {31'd0, cpu_stall}, {31'd0, e_stall});
        check("cpu_rdata", cpu_rdata, e_rdata);
        check("aux_ack", {31'd0, aux_ack}, {31'd0, m_ack});
        check("aux_rdata", aux_rdata, m_aux_rdata);
    endtask

    // Master behaviour: what each master presents this cycle.
    task automatic choose();
        if (mode == 2) begin
            nx_busy  = ($urandom_range(0, 3) == 0);
            nx_rdata = $urandom;
            if (m_cpu_done_prev || !(nx_cpu_rd || nx_cpu_wr)) begin
                int op = $urandom_range(0, 4);
                nx_cpu_rd    = (op == 2) || (op == 4);
                nx_cpu_wr    = (op == 3) || (op == 4);
                nx_cpu_addr  = $urandom; nx_cpu_wdata = $urandom;
                nx_cpu_mask  = 4'($urandom);
            end else if (m_owner == 0 && m_issued) begin
                nx_cpu_addr = $urandom; nx_cpu_wdata = $urandom; nx_cpu_mask = 4'($urandom);
            end
            if (m_ack || !nx_aux_req) begin
                nx_aux_req = ($urandom_range(0, 2) == 0);
                nx_aux_we  = 1'($urandom);
                nx_aux_addr = $urandom; nx_aux_wdata = $urandom; nx_aux_mask = 4'($urandom);
            end else if (m_owner == 1 && m_issued) begin
                nx_aux_we = 1'($urandom);
                nx_aux_addr = $urandom; nx_aux_wdata = $urandom; nx_aux_mask = 4'($urandom);
            end
        end else if (mode == 1) begin
            if (m_cpu_done_prev) begin
                nx_cpu_rd = 1; nx_cpu_wr = 0; nx_cpu_addr = nx_cpu_addr + 32'd4;
            end
            if (m_ack) nx_aux_addr = nx_aux_addr + 32'd4;
        end else begin
            if (m_cpu_done_prev) begin
                nx_cpu_rd = 0; nx_cpu_wr = 0;
            end
            if (m_ack) nx_aux_req = 0;
        end
    endtask

    task automatic apply();
        rst_n = nx_rst_n;
        cpu_memread = nx_cpu_rd; cpu_memwrite = nx_cpu_wr;
        cpu_addr = nx_cpu_addr; cpu_wdata = nx_cpu_wdata; cpu_sign_mask = nx_cpu_mask;
        aux_req = nx_aux_req; aux_we = nx_aux_we; aux_addr = nx_aux_addr;
        aux_wdata = nx_aux_wdata; aux_sign_mask = nx_aux_mask;
        mem_busy = nx_busy; mem_rdata = nx_rdata;
    endtask

    task automatic step();
        @(negedge clk);
        choose();
        apply();
        if (!rst_n) model_reset();
        #1;
        compare_all();
        if (cpu_stall) obs_stall++;
        if ((cpu_memread || cpu_memwrite) && !cpu_stall) obs_cpu_done++;
        if (aux_ack) begin
            obs_acks++;
            if (obs_acks == 1) ack1_cpu = obs_cpu_done;
            if (obs_acks == 2) ack2_cpu = obs_cpu_done;
        end
        @(posedge clk);
        model_seq();
    endtask

    task automatic clear_obs();
        obs_stall = 0; obs_acks = 0; obs_cpu_done = 0; ack1_cpu = -1; ack2_cpu = -1;
    endtask

    initial begin
        mode = 0;
        nx_rst_n = 0; nx_cpu_rd = 0; nx_cpu_wr = 0; nx_aux_req = 0; nx_aux_we = 0;
        nx_busy = 0; nx_cpu_addr = '0; nx_cpu_wdata = '0; nx_aux_addr = '0;
        nx_aux_wdata = '0; nx_rdata = '0; nx_cpu_mask = '0; nx_aux_mask = '0;
        apply();
        model_reset();
        clear_obs();

        // Reset state
        repeat (2) step();
        nx_rst_n = 1;
        repeat (2) step();

        // T1: lone CPU load
        clear_obs();
        nx_cpu_rd = 1; nx_cpu_addr = 32'h1004; nx_cpu_mask = 4'hF; nx_rdata = 32'h1122_3344;
        repeat (5) step();
        check("t1_stall_cycles", obs_stall, 2);
        check("t1_cpu_done", obs_cpu_done, 1);

        // T2: lone aux store
        clear_obs();
        nx_aux_req = 1; nx_aux_we = 1; nx_aux_addr = 32'h2000; nx_aux_wdata = 32'hDEAD_BEEF;
        nx_aux_mask = 4'hF;
        repeat (6) step();
        check("t2_ack_count", obs_acks, 1);

        // T3: simultaneous requests, CPU first
        clear_obs();
        nx_cpu_rd = 1; nx_cpu_addr = 32'h3000; nx_rdata = 32'hCAFE_F00D;
        nx_aux_req = 1; nx_aux_we = 0; nx_aux_addr = 32'h3004;
        repeat (10) step();
        check("t3_ack_count", obs_acks, 1);
        check("t3_cpu_before_ack", ack1_cpu, 1);

        // T4: CPU streams loads with aux held
        clear_obs();
        mode = 1;
        nx_cpu_rd = 1; nx_cpu_addr = 32'h4000; nx_aux_req = 1; nx_aux_we = 0; nx_aux_addr = 32'h4800;
        for (int n = 0; n < 120 && obs_acks < 2; n++) step();
        check("t4_ack_count", obs_acks, 2);
        check("t4_cpu_before_ack1", ack1_cpu, LIMIT);
        check("t4_cpu_before_ack2", ack2_cpu, 2 * LIMIT);
        mode = 0;
        nx_aux_req = 0;
        repeat (8) step();

        // T5: CPU store with mem_busy held for 5 wait cycles
        clear_obs();
        nx_cpu_rd = 0; nx_cpu_wr = 1; nx_cpu_addr = 32'h5000; nx_cpu_wdata = 32'h0BAD_F00D;
        step();
        nx_busy = 1;
        repeat (6) step();
        nx_busy = 0;
        repeat (3) step();
        check("t5_stall_cycles", obs_stall, 7);
        check("t5_cpu_done", obs_cpu_done, 1);

        // T6: reset during AUX_WAIT
        clear_obs();
        nx_aux_req = 1; nx_aux_we = 0; nx_aux_addr = 32'h6000; nx_rdata = 32'h1357_9BDF;
        step();
        nx_busy = 1;
        repeat (2) step();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        nx_rst_n = 0;
        repeat (2) step();
        check("t6_no_ack_in_reset", obs_acks, 0);
        nx_rst_n = 1; nx_busy = 0;
        repeat (6) step();
        check("t6_ack_after_reset", obs_acks, 1);

        // Randomized traffic
        mode = 2;
        repeat (1500) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
